vga_color_pipe: RTL and testbench
=================================

Name: vga_color_pipe

Overview:
- Registered, parametrised successor to the combinational pixel colourer.
- Renders the bird and NUM_PIPES pipe pairs for the current VGA pixel through a 2-stage pipeline.
- Object positions are latched once per frame on frame_start so the picture cannot tear mid-frame.
- Accumulates a per-frame bird/pipe pixel-overlap collision flag for the game FSM. Sits between the VGA timing generator and the DAC pins.

Parameters:
- NUM_PIPES, 2, number of pipe pairs (1..8)
- POS_W, 10, width of all pixel and position coordinates
- RGB_W, 12, colour output width
- BIRD_X, 80, bird left edge (fixed column)
- BIRD_W, 30, bird width in pixels
- BIRD_H, 40, bird height in pixels
- PIPE_W, 30, pipe width in pixels
- PIPE_GAP, 140, vertical gap between upper and lower pipe
- V_ACTIVE, 480, visible line count

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- valid  in  1  current pixel is in the active area
- x_pos  in  POS_W  pixel column
- y_pos  in  POS_W  pixel row
- x_pipe  in  NUM_PIPES*POS_W  pipe i right edge (exclusive), slice [i*POS_W +: POS_W]
- y_pipe  in  NUM_PIPES*POS_W  pipe i lower-pipe top row
- y_bird  in  POS_W  bird bottom row (exclusive)
- rgb  out  RGB_W  pixel colour
- rgb_valid  out  1  valid delayed to align with rgb
- collision  out  1  previous frame contained at least one bird/pipe overlap pixel
- collision_stb  out  1  one-cycle pulse when collision is updated

Behaviour:
- Reset (rst_n=0 at posedge):
  - rgb=0, rgb_valid=0, collision=0, collision_stb=0.
  - Shadow position registers cleared to 0; pipeline valid bits cleared.
  - A reset asserted mid-frame discards in-flight pixels.
- Shadow latch: on a cycle with frame_start=1, x_pipe, y_pipe and y_bird load into shadow registers. All geometry uses shadow values only. Input changes at other times have no effect until the next frame_start.
- Stage 1 (cycle N+1):
  - Register valid, x_pos and y_pos.
  - Compute bird_hit and pipe_hit[i] from the stage-0 pixel against the shadow registers.
- Stage 2 (cycle N+2):
  - rgb and rgb_valid are driven. Latency is exactly 2 cycles, with no stalls.
- Geometry: all compares are done in POS_W+2 bits, adding on the pixel side so nothing wraps.
  - bird_hit: x_pos>=BIRD_X and x_pos<BIRD_X+BIRD_W and y_pos+BIRD_H>=y_bird and y_pos<y_bird.
  - pipe_hit[i]: x_pos+PIPE_W>=x_pipe[i] and x_pos<x_pipe[i] and (y_pos+PIPE_GAP<y_pipe[i] or (y_pos>=y_pipe[i] and y_pos<V_ACTIVE)).
  - Boundaries: x_pipe[i]<PIPE_W gives a partially visible pipe clipped at column 0. y_pipe[i]<PIPE_GAP gives no upper pipe.
- Colour priority, fixed: !valid -> COL_BLANK; bird -> COL_BIRD; any pipe_hit -> COL_PIPE; else COL_BG.
- Collision:
  - An internal hit_acc sets on any stage-1 cycle where valid and bird_hit and |pipe_hit.
  - On frame_start: collision<=hit_acc | (current-cycle overlap), collision_stb<=1, hit_acc<=0.
  - This gives frame_start priority; the overlap pixel is folded into the closing frame.
  - collision holds its value between strobes.

Decomposition:
- Shared package vga_pkg holds:
  - COL_BIRD=12'h000, COL_PIPE=12'h3cf, COL_BG=12'hfff, COL_BLANK=12'h000
  - default geometry constants (BIRD_X, BIRD_W, BIRD_H, PIPE_W, PIPE_GAP, V_ACTIVE, H_ACTIVE=640)
- One sub-module, vga_pipe_hit: combinational single-pipe hit test, generated NUM_PIPES times.

Test Plan:
1. Reset, then frame_start with y_bird=200, x_pipe={300,500}, y_pipe={250,350}. Drive valid pixel (90,170) -> rgb=000 two cycles later; rgb_valid=1.
2. Same frame: pixel (285,50) -> 3cf (upper pipe 0). Pixel (285,150) -> fff (gap, 150+140=290 not <250, and 150<250). Pixel (285,260) -> 3cf. Pixel (300,260) -> fff.
3. Mid-frame, change y_bird to 100 without frame_start. Pixel (90,170) stays 000; after the next frame_start the same pixel gives fff.
4. Latch x_pipe0=100, y_pipe0=190, y_bird=200. Scan pixel (95,195) valid -> at next frame_start collision=1 with collision_stb pulse. The following clean frame gives collision=0.
5. valid=0 with pixel inside the bird -> rgb=000 and rgb_valid=0. valid=0 with pixel inside a pipe -> rgb=000, no collision accumulated.
6. NUM_PIPES=4 with x_pipe3=20: pixel (0,470) -> 3cf (clipped pipe). Assert rst_n=0 mid-stream -> rgb=0 and collision=0 next cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared colours and default geometry for the VGA colour pipeline.
package vga_pkg;

    localparam logic [11:0] COL_BIRD  = 12'h000;
    localparam logic [11:0] COL_PIPE  = 12'h3cf;
    localparam logic [11:0] COL_BG    = 12'hfff;
    localparam logic [11:0] COL_BLANK = 12'h000;

    localparam int unsigned BIRD_X   = 80;
    localparam int unsigned BIRD_W   = 30;
    localparam int unsigned BIRD_H   = 40;
    localparam int unsigned PIPE_W   = 30;
    localparam int unsigned PIPE_GAP = 140;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned H_ACTIVE = 640;

endpackage

// File: rtl/vga_pipe_hit.sv
// Combinational hit test of one pixel against a single upper/lower pipe pair.
module vga_pipe_hit #(
    parameter int unsigned POS_W    = 10,
    parameter int unsigned PIPE_W   = 30,
    parameter int unsigned PIPE_GAP = 140,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic [POS_W-1:0] xPos,
    input  logic [POS_W-1:0] yPos,
    input  logic [POS_W-1:0] xPipe,
    input  logic [POS_W-1:0] yPipe,
    output logic             hit
);

    localparam int unsigned CW = POS_W + 2;

    logic [CW-1:0] xe, ye, xp, yp;
    logic          inCols, inUpper, inLower;

    // Offsets are added on the pixel side so a pipe near column/row 0 clips instead of wrapping.
    always_comb begin
        xe      = {2'b00, xPos};
        ye      = {2'b00, yPos};
        xp      = {2'b00, xPipe};
        yp      = {2'b00, yPipe};
        inCols  = (xe + CW'(PIPE_W) >= xp) && (xe < xp);
        inUpper = (ye + CW'(PIPE_GAP) < yp);
        inLower = (ye >= yp) && (ye < CW'(V_ACTIVE));
        hit     = inCols && (inUpper || inLower);
    end

endmodule

// File: rtl/vga_color_pipe.sv
// Two-stage pixel colourer for bird and pipes, with frame-latched geometry and collision flag.
module vga_color_pipe
    import vga_pkg::*;
#(
    parameter int unsigned NUM_PIPES = 2,
    parameter int unsigned POS_W     = 10,
    parameter int unsigned RGB_W     = 12,
    parameter int unsigned BIRD_X    = vga_pkg::BIRD_X,
    parameter int unsigned BIRD_W    = vga_pkg::BIRD_W,
    parameter int unsigned BIRD_H    = vga_pkg::BIRD_H,
    parameter int unsigned PIPE_W    = vga_pkg::PIPE_W,
    parameter int unsigned PIPE_GAP  = vga_pkg::PIPE_GAP,
    parameter int unsigned V_ACTIVE  = vga_pkg::V_ACTIVE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_start,
    input  logic                       valid,
    input  logic [POS_W-1:0]           x_pos,
    input  logic [POS_W-1:0]           y_pos,
    input  logic [NUM_PIPES*POS_W-1:0] x_pipe,
    input  logic [NUM_PIPES*POS_W-1:0] y_pipe,
    input  logic [POS_W-1:0]           y_bird,
    output logic [RGB_W-1:0]           rgb,
    output logic                       rgb_valid,
    output logic                       collision,
    output logic                       collision_stb
);

    localparam int unsigned CW = POS_W + 2;

    logic [NUM_PIPES*POS_W-1:0] xPipeSh, yPipeSh;
    logic [POS_W-1:0]           yBirdSh;
    logic [NUM_PIPES-1:0]       pipeHit;
    logic                       birdHit;
    logic                       s1Valid, s1Bird, s1Pipe;
    logic                       hitAcc, overlap;
    logic [RGB_W-1:0]           rgbNext;

    for (genvar i = 0; i < NUM_PIPES; i++) begin : gPipe
        vga_pipe_hit #(
            .POS_W   (POS_W),
            .PIPE_W  (PIPE_W),
            .PIPE_GAP(PIPE_GAP),
            .V_ACTIVE(V_ACTIVE)
        ) uHit (
            .xPos (x_pos),
            .yPos (y_pos),
            .xPipe(xPipeSh[i*POS_W +: POS_W]),
            .yPipe(yPipeSh[i*POS_W +: POS_W]),
            .hit  (pipeHit[i])
        );
    end

    always_comb begin
        birdHit = ({2'b00, x_pos} >= CW'(BIRD_X))
               && ({2'b00, x_pos} < CW'(BIRD_X + BIRD_W))
               && ({2'b00, y_pos} + CW'(BIRD_H) >= {2'b00, yBirdSh})
               && ({2'b00, y_pos} < {2'b00, yBirdSh});
        overlap = s1Valid && s1Bird && s1Pipe;
        if (!s1Valid)    rgbNext = RGB_W'(COL_BLANK);
        else if (s1Bird) rgbNext = RGB_W'(COL_BIRD);
        else if (s1Pipe) rgbNext = RGB_W'(COL_PIPE);
        else             rgbNext = RGB_W'(COL_BG);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xPipeSh       <= '0;
            yPipeSh       <= '0;
            yBirdSh       <= '0;
            s1Valid       <= 1'b0;
            s1Bird        <= 1'b0;
            s1Pipe        <= 1'b0;
            rgb           <= '0;
            rgb_valid     <= 1'b0;
            hitAcc        <= 1'b0;
            collision     <= 1'b0;
            collision_stb <= 1'b0;
        end else begin
            if (frame_start) begin
                xPipeSh <= x_pipe;
                yPipeSh <= y_pipe;
                yBirdSh <= y_bird;
            end
            s1Valid   <= valid;
            s1Bird    <= birdHit;
            s1Pipe    <= |pipeHit;
            rgb       <= rgbNext;
            rgb_valid <= s1Valid;
            // An overlap seen on the closing cycle still belongs to the frame being reported.
            if (frame_start) begin
                collision     <= hitAcc | overlap;
                collision_stb <= 1'b1;
                hitAcc        <= 1'b0;
            end else begin
                collision_stb <= 1'b0;
                if (overlap) hitAcc <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_color_pipe.sv
// Directed bench for vga_color_pipe: colours, latency, frame latching, collision and reset.
module tb_vga_color_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        valid;
    logic [9:0]  x_pos, y_pos, y_bird;
    logic [19:0] x_pipe, y_pipe;
    logic [39:0] x_pipe4, y_pipe4;
    logic [11:0] rgb, rgb4;
    logic        rgb_valid, collision, collision_stb;
    logic        rgb_valid4, collision4, collision_stb4;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    vga_color_pipe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .valid        (valid),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .x_pipe       (x_pipe),
        .y_pipe       (y_pipe),
        .y_bird       (y_bird),
        .rgb          (rgb),
        .rgb_valid    (rgb_valid),
        .collision    (collision),
        .collision_stb(collision_stb)
    );

    vga_color_pipe #(.NUM_PIPES(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .valid        (valid),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .x_pipe       (x_pipe4),
        .y_pipe       (y_pipe4),
        .y_bird       (y_bird),
        .rgb          (rgb4),
        .rgb_valid    (rgb_valid4),
        .collision    (collision4),
        .collision_stb(collision_stb4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one pixel for a single cycle; returns after its result has reached the outputs.
    task automatic pix(input int x, input int y, input logic v);
        @(negedge clk);
        x_pos = 10'(x);
        y_pos = 10'(y);
        valid = v;
        @(negedge clk);
        valid = 1'b0;
        if (v) chk("latency", 32'(rgb_valid), 32'd0);
        @(negedge clk);
    endtask

    task automatic fsChk(input string tag, input logic expCol);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk({tag, "_col"}, 32'(collision), 32'(expCol));
        chk({tag, "_stb"}, 32'(collision_stb), 32'd1);
        @(negedge clk);
        chk({tag, "_stb_off"}, 32'(collision_stb), 32'd0);
        chk({tag, "_hold"}, 32'(collision), 32'(expCol));
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        valid       = 1'b0;
        x_pos       = '0;
        y_pos       = '0;
        y_bird      = '0;
        x_pipe      = '0;
        y_pipe      = '0;
        x_pipe4     = {10'd20, 10'd1000, 10'd1000, 10'd1000};
        y_pipe4     = {10'd400, 10'd0, 10'd0, 10'd0};
        repeat (3) @(negedge clk);
        chk("rst_rgb", 32'(rgb), 32'h000);
        chk("rst_rgb_valid", 32'(rgb_valid), 32'd0);
        chk("rst_col", 32'(collision), 32'd0);
        chk("rst_stb", 32'(collision_stb), 32'd0);
        rst_n = 1'b1;

        // Frame A: bird bottom 200, pipes at 300/500.
        y_bird = 10'd200;
        x_pipe = {10'd500, 10'd300};
        y_pipe = {10'd350, 10'd250};
        fsChk("fsA", 1'b0);
        pix(90, 170, 1'b1);
        chk("bird_rgb", 32'(rgb), 32'h000);
        chk("bird_valid", 32'(rgb_valid), 32'd1);
        pix(285, 50, 1'b1);
        chk("upper_pipe", 32'(rgb), 32'h3cf);
        pix(285, 150, 1'b1);
        chk("gap", 32'(rgb), 32'hfff);
        pix(285, 260, 1'b1);
        chk("lower_pipe", 32'(rgb), 32'h3cf);
        pix(300, 260, 1'b1);
        chk("pipe_right_edge", 32'(rgb), 32'hfff);

        // Input change without frame_start must not move the bird.
        y_bird = 10'd100;
        pix(90, 170, 1'b1);
        chk("shadow_hold", 32'(rgb), 32'h000);
        fsChk("fsB", 1'b0);
        pix(90, 170, 1'b1);
        chk("shadow_load", 32'(rgb), 32'hfff);

        // Overlapping bird and pipe.
        x_pipe = {10'd500, 10'd100};
        y_pipe = {10'd350, 10'd190};
        y_bird = 10'd200;
        fsChk("fsC", 1'b0);
        pix(95, 195, 1'b1);
        chk("overlap_rgb", 32'(rgb), 32'h000);
        fsChk("fsD", 1'b1);
        pix(285, 260, 1'b1);
        chk("clean_px", 32'(rgb), 32'hfff);
        fsChk("fsE", 1'b0);

        // Invalid pixels: blanked and never counted as collisions.
        pix(95, 195, 1'b0);
        chk("inv_bird_rgb", 32'(rgb), 32'h000);
        chk("inv_bird_valid", 32'(rgb_valid), 32'd0);
        pix(95, 300, 1'b0);
        chk("inv_pipe_rgb", 32'(rgb), 32'h000);
        chk("inv_pipe_valid", 32'(rgb_valid), 32'd0);
        fsChk("fsF", 1'b0);

        // Four-pipe instance: pipe 3 clipped at column 0.
        pix(0, 470, 1'b1);
        chk("clip_rgb", 32'(rgb4), 32'h3cf);
        chk("clip_valid", 32'(rgb_valid4), 32'd1);
        pix(19, 479, 1'b1);
        chk("clip_last", 32'(rgb4), 32'h3cf);
        pix(20, 470, 1'b1);
        chk("clip_edge", 32'(rgb4), 32'hfff);
        pix(0, 480, 1'b1);
        chk("v_active_edge", 32'(rgb4), 32'hfff);

        // Reset mid-stream with a pipe pixel in flight and collision set.
        pix(95, 195, 1'b1);
        fsChk("fsG", 1'b1);
        @(negedge clk);
        x_pos = 10'd95;
        y_pos = 10'd300;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_rgb", 32'(rgb), 32'h000);
        chk("mid_rst_valid", 32'(rgb_valid), 32'd0);
        chk("mid_rst_col", 32'(collision), 32'd0);
        chk("mid_rst_stb", 32'(collision_stb), 32'd0);
        chk("mid_rst_rgb4", 32'(rgb4), 32'h000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(rgb_valid), 32'd0);
        // Shadows are cleared, so the old bird position no longer draws.
        pix(90, 170, 1'b1);
        chk("shadow_cleared", 32'(rgb), 32'hfff);
        fsChk("fsH", 1'b0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
